// File: rtl/gat_pkg.sv
// Shared definitions for the BRAM read-port arbiter: FSM state encoding and
// requester IDs carried through the read tag pipeline.
package gat_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_W = 2'd1,
        GRANT_A = 2'd2
    } arb_state_t;

    localparam logic REQ_W = 1'b0;
    localparam logic REQ_A = 1'b1;
endpackage

// File: rtl/param_bram_arbiter_if.sv
// Bus bundle between the two loaders, the arbiter and the shared BRAM port B.
// slave = arbiter side, master = loaders + BRAM side.
interface param_bram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 15
);
    logic                  w_req_vld;
    logic [ADDR_W-1:0]     w_req_addr;
    logic                  w_req_rdy;
    logic                  w_rsp_vld;
    logic [DATA_WIDTH-1:0] w_rsp_data;

    logic                  a_req_vld;
    logic [ADDR_W-1:0]     a_req_addr;
    logic                  a_req_rdy;
    logic                  a_rsp_vld;
    logic [DATA_WIDTH-1:0] a_rsp_data;

    logic                  bram_enb;
    logic [ADDR_W-1:0]     bram_addrb;
    logic [DATA_WIDTH-1:0] bram_dout;

    modport slave (
        input  w_req_vld, w_req_addr, a_req_vld, a_req_addr, bram_dout,
        output w_req_rdy, w_rsp_vld, w_rsp_data,
        output a_req_rdy, a_rsp_vld, a_rsp_data,
        output bram_enb, bram_addrb
    );

    modport master (
        output w_req_vld, w_req_addr, a_req_vld, a_req_addr, bram_dout,
        input  w_req_rdy, w_rsp_vld, w_rsp_data,
        input  a_req_rdy, a_rsp_vld, a_rsp_data,
        input  bram_enb, bram_addrb
    );
endinterface

// File: rtl/rd_tag_pipe.sv
// Delay line for {valid, id} matching the BRAM read latency, so each issued
// read is steered back to the requester that made it.
module rd_tag_pipe #(
    parameter int READ_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_vld,
    input  logic in_id,
    output logic out_vld,
    output logic out_id,
    output logic any_vld
);
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [READ_LATENCY-1:0] id_pipe;

    // Shift tags one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            id_pipe[0]  <= in_id;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[READ_LATENCY-1];
    assign out_id  = id_pipe[READ_LATENCY-1];
    assign any_vld = |vld_pipe;
endmodule

// File: rtl/param_bram_arbiter.sv
// Two-requester arbiter for a shared BRAM read port. Grants are held for
// bursts of up to MAX_BURST beats, alternate fairly under contention, and
// read data is routed back by a tag pipeline in acceptance order.
module param_bram_arbiter
    import gat_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_W       = 15,
    parameter int READ_LATENCY = 2,   // legal 1..4
    parameter int MAX_BURST    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    param_bram_arbiter_if.slave  bus,
    output logic                 busy
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t        state;
    logic              last_srv;      // requester that most recently left a grant
    logic [CNT_W-1:0]  burst_cnt;

    logic              w_acc, a_acc, acc;
    logic              burst_last;
    logic              rd_enb_q, rd_id_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              tag_vld, tag_id, tag_any;
    logic [DATA_WIDTH-1:0] rd_data;

    // Ready comes only from the state register; reset blocks any acceptance.
    assign bus.w_req_rdy = (state == GRANT_W) & ~rst;
    assign bus.a_req_rdy = (state == GRANT_A) & ~rst;
    assign w_acc         = bus.w_req_rdy & bus.w_req_vld;
    assign a_acc         = bus.a_req_rdy & bus.a_req_vld;
    assign acc           = w_acc | a_acc;
    assign burst_last    = (burst_cnt == CNT_W'(MAX_BURST - 1));

    // Grant FSM with burst limiting and a last-served fairness pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_srv  <= REQ_A;   // so W wins the first tie
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (bus.w_req_vld && bus.a_req_vld)
                        state <= (last_srv == REQ_W) ? GRANT_A : GRANT_W;
                    else if (bus.w_req_vld)
                        state <= GRANT_W;
                    else if (bus.a_req_vld)
                        state <= GRANT_A;
                end
                GRANT_W: begin
                    if (!bus.w_req_vld) begin
                        burst_cnt <= '0;
                        last_srv  <= REQ_W;
                        state     <= bus.a_req_vld ? GRANT_A : IDLE;
                    end else if (burst_last) begin
                        burst_cnt <= '0;
                        if (bus.a_req_vld) begin
                            last_srv <= REQ_W;
                            state    <= GRANT_A;
                        end
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                GRANT_A: begin
                    if (!bus.a_req_vld) begin
                        burst_cnt <= '0;
                        last_srv  <= REQ_A;
                        state     <= bus.w_req_vld ? GRANT_W : IDLE;
                    end else if (burst_last) begin
                        burst_cnt <= '0;
                        if (bus.w_req_vld) begin
                            last_srv <= REQ_A;
                            state    <= GRANT_W;
                        end
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    // Register the accepted beat onto BRAM port B; address holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_enb_q  <= 1'b0;
            rd_id_q   <= REQ_W;
            rd_addr_q <= '0;
        end else begin
            rd_enb_q <= acc;
            rd_id_q  <= a_acc ? REQ_A : REQ_W;
            if (acc)
                rd_addr_q <= a_acc ? bus.a_req_addr : bus.w_req_addr;
        end
    end

    assign bus.bram_enb   = rd_enb_q & ~rst;
    assign bus.bram_addrb = rd_addr_q;

    rd_tag_pipe #(.READ_LATENCY(READ_LATENCY)) u_tag (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (rd_enb_q),
        .in_id   (rd_id_q),
        .out_vld (tag_vld),
        .out_id  (tag_id),
        .any_vld (tag_any)
    );

    // Data fans out to both loaders; only the tagged one sees rsp_vld.
    assign rd_data        = bus.bram_dout;
    assign bus.w_rsp_data = rd_data;
    assign bus.a_rsp_data = rd_data;
    assign bus.w_rsp_vld  = tag_vld & (tag_id == REQ_W) & ~rst;
    assign bus.a_rsp_vld  = tag_vld & (tag_id == REQ_A) & ~rst;

    assign busy = ~rst & ((state != IDLE) | rd_enb_q | tag_any);
endmodule

// File: tb/tb_param_bram_arbiter.sv
// Directed bench: per-cycle vector table on a RL=2 / MAX_BURST=4 arbiter,
// plus hand sequences for burst wrap, reset mid-flight and latency sweep.
module tb_param_bram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy0, busy1, busy4;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    param_bram_arbiter_if #(.DATA_WIDTH(8), .ADDR_W(15)) i0 ();
    param_bram_arbiter_if #(.DATA_WIDTH(8), .ADDR_W(15)) i1 ();
    param_bram_arbiter_if #(.DATA_WIDTH(8), .ADDR_W(15)) i4 ();

    param_bram_arbiter #(.DATA_WIDTH(8), .ADDR_W(15), .READ_LATENCY(2), .MAX_BURST(4))
        u0 (.clk(clk), .rst(rst), .bus(i0.slave), .busy(busy0));
    param_bram_arbiter #(.DATA_WIDTH(8), .ADDR_W(15), .READ_LATENCY(1), .MAX_BURST(16))
        u1 (.clk(clk), .rst(rst), .bus(i1.slave), .busy(busy1));
    param_bram_arbiter #(.DATA_WIDTH(8), .ADDR_W(15), .READ_LATENCY(4), .MAX_BURST(16))
        u4 (.clk(clk), .rst(rst), .bus(i4.slave), .busy(busy4));

    function automatic logic [7:0] mem_f(input logic [14:0] a);
        logic [14:0] p;
        p = a * 15'd29;
        return p[7:0] ^ 8'h5A;
    endfunction

    // BRAM port-B models: registered read, output taken at stage READ_LATENCY-1.
    logic [7:0] bp0 [4];
    logic [7:0] bp1 [4];
    logic [7:0] bp4 [4];
    always @(posedge clk) begin
        if (i0.bram_enb) bp0[0] <= mem_f(i0.bram_addrb);
        if (i1.bram_enb) bp1[0] <= mem_f(i1.bram_addrb);
        if (i4.bram_enb) bp4[0] <= mem_f(i4.bram_addrb);
        for (int k = 1; k < 4; k++) begin
            bp0[k] <= bp0[k-1];
            bp1[k] <= bp1[k-1];
            bp4[k] <= bp4[k-1];
        end
    end
    assign i0.bram_dout = bp0[1];
    assign i1.bram_dout = bp1[0];
    assign i4.bram_dout = bp4[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit rst, wv; int wa; bit av; int aa;
        bit erw, era, een, ca; int eaddr;
        bit ewr, ear; int dadr; bit ebusy;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit rs, wv, input int wa, input bit av, input int aa,
                                input bit erw, era, een, ca, input int eaddr,
                                input bit ewr, ear, input int dadr, input bit ebusy);
        vec_t v;
        v.rst = rs; v.wv = wv; v.wa = wa; v.av = av; v.aa = aa;
        v.erw = erw; v.era = era; v.een = een; v.ca = ca; v.eaddr = eaddr;
        v.ewr = ewr; v.ear = ear; v.dadr = dadr; v.ebusy = ebusy;
        tbl.push_back(v);
    endfunction

    task automatic run_row(input vec_t r, input int i);
        @(posedge clk); #1;
        rst = r.rst;
        i0.w_req_vld = r.wv; i0.w_req_addr = 15'(r.wa);
        i0.a_req_vld = r.av; i0.a_req_addr = 15'(r.aa);
        @(negedge clk);
        chk($sformatf("r%0d w_rdy", i), 32'(i0.w_req_rdy), 32'(r.erw));
        chk($sformatf("r%0d a_rdy", i), 32'(i0.a_req_rdy), 32'(r.era));
        chk($sformatf("r%0d enb", i), 32'(i0.bram_enb), 32'(r.een));
        if (r.ca) chk($sformatf("r%0d addrb", i), 32'(i0.bram_addrb), 32'(r.eaddr));
        chk($sformatf("r%0d w_rsp", i), 32'(i0.w_rsp_vld), 32'(r.ewr));
        chk($sformatf("r%0d a_rsp", i), 32'(i0.a_rsp_vld), 32'(r.ear));
        chk($sformatf("r%0d busy", i), 32'(busy0), 32'(r.ebusy));
        if (r.ewr) chk($sformatf("r%0d w_data", i), 32'(i0.w_rsp_data), 32'(mem_f(15'(r.dadr))));
        if (r.ear) chk($sformatf("r%0d a_data", i), 32'(i0.a_rsp_data), 32'(mem_f(15'(r.dadr))));
    endtask

    task automatic idle_inputs();
        i0.w_req_vld = 0; i0.a_req_vld = 0; i1.w_req_vld = 0; i1.a_req_vld = 0;
        i4.w_req_vld = 0; i4.a_req_vld = 0;
        i0.w_req_addr = '0; i0.a_req_addr = '0; i1.w_req_addr = '0; i1.a_req_addr = '0;
        i4.w_req_addr = '0; i4.a_req_addr = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1; idle_inputs();
        @(posedge clk); #1; rst = 0;
    endtask

    // One beat through the RL=1 (W side) or RL=4 (A side) instance.
    task automatic sweep(input int rl);
        int acc_c, rsp_c;
        logic [7:0] dat;
        acc_c = -1; rsp_c = -1; dat = '0;
        do_reset();
        if (rl == 1) begin i1.w_req_vld = 1; i1.w_req_addr = 15'h123; end
        else begin i4.a_req_vld = 1; i4.a_req_addr = 15'h2BC; end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if ((rl == 1) ? i1.w_req_rdy : i4.a_req_rdy) begin acc_c = cyc; break; end
        end
        @(posedge clk); #1;
        i1.w_req_vld = 0; i4.a_req_vld = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if ((rl == 1) ? i1.w_rsp_vld : i4.a_rsp_vld) begin
                rsp_c = cyc;
                dat = (rl == 1) ? i1.w_rsp_data : i4.a_rsp_data;
                break;
            end
        end
        chk($sformatf("rl%0d accepted", rl), 32'(acc_c >= 0), 32'd1);
        chk($sformatf("rl%0d latency", rl), 32'(rsp_c - acc_c), 32'(rl + 1));
        chk($sformatf("rl%0d data", rl), 32'(dat), 32'(mem_f((rl == 1) ? 15'h123 : 15'h2BC)));
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        // Seq A: W alone, addresses 0..4, beats continue across the burst limit
        add(1,0,0,0,0, 0,0,0,0,0, 0,0,0,0);
        add(0,1,0,0,0, 0,0,0,1,0, 0,0,0,0);
        add(0,1,0,0,0, 1,0,0,1,0, 0,0,0,1);
        add(0,1,1,0,0, 1,0,1,1,0, 0,0,0,1);
        add(0,1,2,0,0, 1,0,1,1,1, 0,0,0,1);
        add(0,1,3,0,0, 1,0,1,1,2, 1,0,0,1);
        add(0,1,4,0,0, 1,0,1,1,3, 1,0,1,1);
        add(0,0,0,0,0, 1,0,1,1,4, 1,0,2,1);
        add(0,0,0,0,0, 0,0,0,1,4, 1,0,3,1);
        add(0,0,0,0,0, 0,0,0,1,4, 1,0,4,1);
        add(0,0,0,0,0, 0,0,0,1,4, 0,0,0,0);
        // Seq B: both requesters stream; W,A,W grants of 4 beats, no gap
        add(1,1,'h40,1,'h80, 0,0,0,0,0, 0,0,0,0);
        add(0,1,'h41,1,'h81, 0,0,0,1,0, 0,0,0,0);
        add(0,1,'h42,1,'h82, 1,0,0,1,0, 0,0,0,1);
        add(0,1,'h43,1,'h83, 1,0,1,1,'h42, 0,0,0,1);
        add(0,1,'h44,1,'h84, 1,0,1,1,'h43, 0,0,0,1);
        add(0,1,'h45,1,'h85, 1,0,1,1,'h44, 1,0,'h42,1);
        add(0,1,'h46,1,'h86, 0,1,1,1,'h45, 1,0,'h43,1);
        add(0,1,'h47,1,'h87, 0,1,1,1,'h86, 1,0,'h44,1);
        add(0,1,'h48,1,'h88, 0,1,1,1,'h87, 1,0,'h45,1);
        add(0,1,'h49,1,'h89, 0,1,1,1,'h88, 0,1,'h86,1);
        add(0,1,'h4A,1,'h8A, 1,0,1,1,'h89, 0,1,'h87,1);
        add(0,1,'h4B,1,'h8B, 1,0,1,1,'h4A, 0,1,'h88,1);
        add(0,0,0,0,0, 1,0,1,1,'h4B, 0,1,'h89,1);
        add(0,0,0,0,0, 0,0,0,1,'h4B, 1,0,'h4A,1);
        add(0,0,0,0,0, 0,0,0,1,'h4B, 1,0,'h4B,1);
        add(0,0,0,0,0, 0,0,0,1,'h4B, 0,0,0,0);
        // Seq D: W drops vld while A waits; last W data still returns
        add(1,0,0,0,0, 0,0,0,0,0, 0,0,0,0);
        add(0,1,'h101,1,'h201, 0,0,0,1,0, 0,0,0,0);
        add(0,1,'h102,1,'h202, 1,0,0,1,0, 0,0,0,1);
        add(0,1,'h103,1,'h203, 1,0,1,1,'h102, 0,0,0,1);
        add(0,0,0,1,'h204, 1,0,1,1,'h103, 0,0,0,1);
        add(0,0,0,1,'h205, 0,1,0,1,'h103, 1,0,'h102,1);
        add(0,0,0,0,0, 0,1,1,1,'h205, 1,0,'h103,1);
        add(0,0,0,0,0, 0,0,0,1,'h205, 0,0,0,1);
        add(0,0,0,0,0, 0,0,0,1,'h205, 0,1,'h205,1);
        add(0,0,0,0,0, 0,0,0,1,'h205, 0,0,0,0);
        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

        // Seq C: W streams alone; burst counter wraps after every 4th beat
        do_reset();
        i0.w_req_vld = 1; i0.w_req_addr = 15'd0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            i0.w_req_addr = 15'(k);
            @(negedge clk);
            chk($sformatf("burst k%0d rdy", k), 32'(i0.w_req_rdy), 32'd1);
            chk($sformatf("burst k%0d cnt", k), 32'(u0.burst_cnt), 32'((k - 1) % 4));
        end

        // Seq E: reset with two reads in flight
        do_reset();
        i0.w_req_vld = 1; i0.w_req_addr = 15'h300;
        @(posedge clk); #1;
        @(negedge clk); chk("rst_e1 w_rdy", 32'(i0.w_req_rdy), 32'd1);
        @(posedge clk); #1; i0.w_req_addr = 15'h301;
        @(negedge clk); chk("rst_e2 w_rdy", 32'(i0.w_req_rdy), 32'd1);
        @(posedge clk); #1; rst = 1; i0.w_req_vld = 0;
        @(negedge clk);
        chk("rst_e3 w_rdy", 32'(i0.w_req_rdy), 32'd0);
        chk("rst_e3 enb", 32'(i0.bram_enb), 32'd0);
        chk("rst_e3 busy", 32'(busy0), 32'd0);
        @(posedge clk); #1; rst = 0;
        i0.w_req_vld = 1; i0.w_req_addr = 15'h310; i0.a_req_vld = 1; i0.a_req_addr = 15'h410;
        @(negedge clk);
        chk("rst_e4 busy", 32'(busy0), 32'd0);
        chk("rst_e4 rsp", 32'({i0.w_rsp_vld, i0.a_rsp_vld}), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_e5 w_rdy", 32'(i0.w_req_rdy), 32'd1);
        chk("rst_e5 a_rdy", 32'(i0.a_req_rdy), 32'd0);
        chk("rst_e5 rsp", 32'({i0.w_rsp_vld, i0.a_rsp_vld}), 32'd0);
        @(posedge clk); #1; i0.w_req_vld = 0; i0.a_req_vld = 0;
        @(negedge clk); chk("rst_e6 rsp", 32'({i0.w_rsp_vld, i0.a_rsp_vld}), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("rst_e7 rsp", 32'({i0.w_rsp_vld, i0.a_rsp_vld}), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_e8 w_rsp", 32'(i0.w_rsp_vld), 32'd1);
        chk("rst_e8 w_data", 32'(i0.w_rsp_data), 32'(mem_f(15'h310)));

        // Latency sweep
        sweep(1);
        sweep(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
